// File: rtl/imem_loader.sv
// Byte-stream program loader: packs big-endian bytes into 32-bit words, writes them to IMEM,
// verifies an XOR checksum and then releases the core with a PC load pulse.
module imem_loader #(
    parameter int unsigned ADDR_W   = 6,
    parameter logic [7:0]  START_PC = 8'h00
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic              LD_start,
    input  logic [7:0]        LD_byte,
    input  logic              LD_valid,
    output logic              LD_ready,
    output logic [ADDR_W-1:0] IMEM_addr,
    output logic [31:0]       IMEM_data,
    output logic              IMEM_we,
    output logic              CPU_hold,
    output logic              CPU_load,
    output logic [7:0]        CPU_pc_val,
    output logic              LD_busy,
    output logic              LD_done,
    output logic              LD_error
);

    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam int unsigned CAP   = 1 << ADDR_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COUNT   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_ERROR   = 3'd7;

    logic [2:0]       state_q;
    logic [2:0]       state_nxt;
    logic [IDX_W-1:0] count_q;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       byte_cnt_q;
    logic [23:0]      word_q;
    logic [7:0]       xor_q;
    logic             accept;
    logic             count_bad;
    logic             idx_last;
    logic             start_ok;

    assign accept     = LD_valid && LD_ready;
    assign count_bad  = (LD_byte == 8'd0) || (32'(LD_byte) > CAP);
    assign idx_last   = (idx_q == (count_q - IDX_W'(1)));
    assign start_ok   = LD_start && (state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign CPU_pc_val = START_PC;

    // State register
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (LD_start) state_nxt = S_COUNT;
            end
            S_COUNT: begin
                if (accept) state_nxt = count_bad ? S_ERROR : S_DATA;
            end
            S_DATA: begin
                if (accept && (byte_cnt_q == 2'd3)) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                state_nxt = idx_last ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                if (accept) state_nxt = (LD_byte == xor_q) ? S_RELEASE : S_ERROR;
            end
            S_RELEASE: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Control outputs are registered copies of the decode of the upcoming state
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            LD_ready <= 1'b0;
            IMEM_we  <= 1'b0;
            CPU_hold <= 1'b0;
            CPU_load <= 1'b0;
            LD_busy  <= 1'b0;
            LD_done  <= 1'b0;
            LD_error <= 1'b0;
        end else begin
            LD_ready <= state_nxt inside {S_COUNT, S_DATA, S_CHECK};
            IMEM_we  <= (state_nxt == S_WRITE);
            CPU_hold <= !(state_nxt inside {S_IDLE, S_DONE});
            CPU_load <= (state_nxt == S_RELEASE);
            LD_busy  <= state_nxt inside {S_COUNT, S_DATA, S_WRITE, S_CHECK, S_RELEASE};
            LD_done  <= (state_nxt == S_DONE);
            LD_error <= (state_nxt == S_ERROR);
        end
    end

    // Datapath: word packing, checksum accumulation, word index
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            count_q    <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            xor_q      <= '0;
            IMEM_addr  <= '0;
            IMEM_data  <= '0;
        end else if (start_ok) begin
            idx_q      <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            xor_q      <= '0;
        end else begin
            case (state_q)
                S_COUNT: begin
                    if (accept && !count_bad) count_q <= IDX_W'(LD_byte);
                end
                S_DATA: begin
                    if (accept) begin
                        word_q     <= {word_q[15:0], LD_byte};
                        xor_q      <= xor_q ^ LD_byte;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        // Fourth byte completes the word; present it with its address in WRITE
                        if (byte_cnt_q == 2'd3) begin
                            IMEM_data <= {word_q, LD_byte};
                            IMEM_addr <= idx_q[ADDR_W-1:0];
                        end
                    end
                end
                S_WRITE: begin
                    idx_q <= idx_q + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed vector table, randomized sessions against a
// stream-level reference model, plus full-capacity and mid-session reset sequences.
module tb_imem_loader;

    localparam int unsigned ADDR_W   = 6;
    localparam logic [7:0]  START_PC = 8'h00;

    logic              SYS_clk;
    logic              SYS_reset;
    logic              LD_start;
    logic [7:0]        LD_byte;
    logic              LD_valid;
    logic              LD_ready;
    logic [ADDR_W-1:0] IMEM_addr;
    logic [31:0]       IMEM_data;
    logic              IMEM_we;
    logic              CPU_hold;
    logic              CPU_load;
    logic [7:0]        CPU_pc_val;
    logic              LD_busy;
    logic              LD_done;
    logic              LD_error;

    imem_loader #(.ADDR_W(ADDR_W), .START_PC(START_PC)) dut (
        .SYS_clk   (SYS_clk),
        .SYS_reset (SYS_reset),
        .LD_start  (LD_start),
        .LD_byte   (LD_byte),
        .LD_valid  (LD_valid),
        .LD_ready  (LD_ready),
        .IMEM_addr (IMEM_addr),
        .IMEM_data (IMEM_data),
        .IMEM_we   (IMEM_we),
        .CPU_hold  (CPU_hold),
        .CPU_load  (CPU_load),
        .CPU_pc_val(CPU_pc_val),
        .LD_busy   (LD_busy),
        .LD_done   (LD_done),
        .LD_error  (LD_error)
    );

    initial SYS_clk = 1'b0;
    always #5 SYS_clk = ~SYS_clk;

    int checks = 0;
    int errors = 0;

    // Observed IMEM writes and CPU_load pulses
    logic [ADDR_W+31:0] wr_log[$];
    int   load_cnt = 0;
    int   we_long  = 0;
    logic we_prev  = 1'b0;

    always @(negedge SYS_clk) begin
        if (IMEM_we) wr_log.push_back({IMEM_addr, IMEM_data});
        if (CPU_load) load_cnt <= load_cnt + 1;
        if (IMEM_we && we_prev) we_long <= we_long + 1;
        we_prev <= IMEM_we;
    end

    // Stream under test and reference-model results
    logic [7:0]  stream_q[$];
    logic [31:0] m_words[$];
    bit          m_ok;
    int          m_len;

    typedef struct {
        logic [111:0] bytes;
        int           len;
        int           gap;
        bit           mid_start;
        bit           exp_ok;
        int           exp_nw;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge SYS_clk);
        #1;
    endtask

    // Stream-level model: count byte, N big-endian words, XOR checksum
    task automatic model();
        int n;
        logic [7:0] x;
        m_words.delete();
        n = int'(stream_q[0]);
        if (n == 0 || n > (1 << ADDR_W)) begin
            m_ok  = 1'b0;
            m_len = 1;
        end else begin
            x = 8'h00;
            for (int i = 0; i < n; i++) begin
                m_words.push_back({stream_q[1+4*i], stream_q[2+4*i], stream_q[3+4*i], stream_q[4+4*i]});
                x = x ^ stream_q[1+4*i] ^ stream_q[2+4*i] ^ stream_q[3+4*i] ^ stream_q[4+4*i];
            end
            m_len = 4 * n + 2;
            m_ok  = (stream_q[4*n+1] == x);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g;
        bit acc;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        LD_valid = 1'b0;
        repeat (g) step();
        LD_valid = 1'b1;
        LD_byte  = b;
        acc = 1'b0;
        for (int c = 0; c < 100 && !acc; c++) begin
            acc = LD_ready;
            step();
        end
        LD_valid = 1'b0;
        chk("byte_accept", 64'(acc), 64'd1);
    endtask

    task automatic run_session(input int gap, input bit mid_start, input bit exp_ok, input int exp_nw);
        int base_w;
        int base_l;
        int k;
        model();
        base_w = wr_log.size();
        base_l = load_cnt;
        LD_start = 1'b1;
        step();
        LD_start = 1'b0;
        chk("start_busy", 64'(LD_busy), 64'd1);
        chk("start_hold", 64'(CPU_hold), 64'd1);
        chk("start_flags", 64'({LD_done, LD_error}), 64'd0);
        for (int i = 0; i < m_len; i++) begin
            if (mid_start && i == 3) LD_start = 1'b1;
            send_byte(stream_q[i], gap);
            LD_start = 1'b0;
            if (i > 0 && (i % 4) == 0 && (i / 4) <= m_words.size()) begin
                k = i / 4 - 1;
                chk("we_after_4th", 64'(IMEM_we), 64'd1);
                chk("we_addr", 64'(IMEM_addr), 64'(k));
                chk("we_data", 64'(IMEM_data), 64'(m_words[k]));
            end
        end
        if (exp_ok) begin
            chk("release_load", 64'(CPU_load), 64'd1);
            chk("release_hold", 64'(CPU_hold), 64'd1);
            step();
            chk("done_load", 64'(CPU_load), 64'd0);
            chk("done_hold", 64'(CPU_hold), 64'd0);
            chk("done_flag", 64'({LD_done, LD_error}), 64'b10);
        end else begin
            step();
            chk("err_flag", 64'({LD_done, LD_error}), 64'b01);
            chk("err_hold", 64'(CPU_hold), 64'd1);
        end
        repeat (2) step();
        chk("write_count", 64'(wr_log.size() - base_w), 64'(exp_nw));
        for (int j = 0; j < m_words.size() && (base_w + j) < wr_log.size(); j++)
            chk("write_entry", 64'(wr_log[base_w+j]), 64'({ADDR_W'(j), m_words[j]}));
        chk("load_pulses", 64'(load_cnt - base_l), 64'(exp_ok));
        chk("idle_busy_ready", 64'({LD_busy, LD_ready, IMEM_we}), 64'd0);
        chk("we_single_cycle", 64'(we_long), 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready_we"}, 64'({LD_ready, IMEM_we}), 64'd0);
        chk({tag, "_addr"}, 64'(IMEM_addr), 64'd0);
        chk({tag, "_data"}, 64'(IMEM_data), 64'd0);
        chk({tag, "_hold_load"}, 64'({CPU_hold, CPU_load}), 64'd0);
        chk({tag, "_busy_done_err"}, 64'({LD_busy, LD_done, LD_error}), 64'd0);
        chk({tag, "_pc_val"}, 64'(CPU_pc_val), 64'(START_PC));
    endtask

    initial begin
        int n;
        bit bad;
        logic [7:0] x;
        logic [7:0] b;
        int wbase;

        vecs[0] = '{bytes: {48'h01_20080005_2D, 64'h0},          len: 6,  gap: 0, mid_start: 1'b0, exp_ok: 1'b1, exp_nw: 1};
        vecs[1] = '{bytes: 112'h03_11111111_22222222_33333333_00, len: 14, gap: 3, mid_start: 1'b0, exp_ok: 1'b1, exp_nw: 3};
        vecs[2] = '{bytes: {8'h00, 104'h0},                       len: 1,  gap: 0, mid_start: 1'b0, exp_ok: 1'b0, exp_nw: 0};
        vecs[3] = '{bytes: {8'h41, 104'h0},                       len: 1,  gap: 1, mid_start: 1'b0, exp_ok: 1'b0, exp_nw: 0};
        vecs[4] = '{bytes: {48'h01_DEADBEEF_00, 64'h0},          len: 6,  gap: 0, mid_start: 1'b0, exp_ok: 1'b0, exp_nw: 1};
        vecs[5] = '{bytes: {80'h02_12345678_CAFEF00D_C1, 32'h0}, len: 10, gap: 2, mid_start: 1'b1, exp_ok: 1'b1, exp_nw: 2};

        SYS_reset = 1'b1;
        LD_start  = 1'b0;
        LD_byte   = 8'h00;
        LD_valid  = 1'b0;
        repeat (3) step();
        chk_reset_vals("reset");
        SYS_reset = 1'b0;
        repeat (2) step();
        chk("idle_no_ready", 64'({LD_ready, CPU_hold}), 64'd0);

        for (int v = 0; v < 6; v++) begin
            stream_q.delete();
            for (int j = 0; j < vecs[v].len; j++) begin
                b = vecs[v].bytes[111-8*j -: 8];
                stream_q.push_back(b);
            end
            run_session(vecs[v].gap, vecs[v].mid_start, vecs[v].exp_ok, vecs[v].exp_nw);
        end

        // Randomized sessions, some with a corrupted checksum
        for (int r = 0; r < 8; r++) begin
            n   = int'($urandom_range(8, 1));
            bad = ($urandom_range(3, 0) == 0);
            stream_q.delete();
            stream_q.push_back(8'(n));
            x = 8'h00;
            for (int j = 0; j < 4 * n; j++) begin
                b = 8'($urandom);
                x = x ^ b;
                stream_q.push_back(b);
            end
            stream_q.push_back(bad ? (x ^ 8'(($urandom_range(255, 1)))) : x);
            run_session(int'($urandom_range(2, 0)), 1'b0, !bad, n);
        end

        // Full capacity: 64 words, word i holds i
        stream_q.delete();
        stream_q.push_back(8'h40);
        x = 8'h00;
        for (int i = 0; i < 64; i++) begin
            stream_q.push_back(8'h00);
            stream_q.push_back(8'h00);
            stream_q.push_back(8'h00);
            stream_q.push_back(8'(i));
            x = x ^ 8'(i);
        end
        stream_q.push_back(x);
        wbase = wr_log.size();
        run_session(0, 1'b0, 1'b1, 64);
        if (wr_log.size() == wbase + 64)
            chk("full_last_addr", 64'(wr_log[wbase+63][ADDR_W+31:32]), 64'd63);

        // Reset after two data bytes of a session
        wbase = wr_log.size();
        LD_start = 1'b1;
        step();
        LD_start = 1'b0;
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        SYS_reset = 1'b1;
        #1;
        chk_reset_vals("midreset");
        step();
        SYS_reset = 1'b0;
        step();
        chk("midreset_no_write", 64'(wr_log.size() - wbase), 64'd0);
        stream_q.delete();
        stream_q = '{8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
        run_session(1, 1'b0, 1'b1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
